// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array and its result drain: state
// encoding, element-width expression and a clog2 helper.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  // Result elements are full-precision products of two operands.
  function automatic int elem_w(input int bitwidth);
    return 2 * bitwidth;
  endfunction

  // Bits needed to index v items, never less than 1.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/drain_settle_timer.sv
// Loadable down-counter that saturates at zero; done is high while the count is zero.
module drain_settle_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          done
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/systolic_result_drain.sv
// Snapshots the systolic array result after a fixed settle time and streams it
// row-major over valid/ready. Optional macro DRAIN_PARITY_EN adds oParity.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int N             = 4,
  parameter int BITWIDTH      = 8,
  parameter int SETTLE_CYCLES = 3 * N - 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  iStart,
  input  logic [N*N*elem_w(BITWIDTH)-1:0]       iRes,
  input  logic                                  iReady,
  output logic                                  oValid,
  output logic [elem_w(BITWIDTH)-1:0]           oData,
  output logic [clog2_min1(N)-1:0]              oRow,
  output logic [clog2_min1(N)-1:0]              oCol,
  output logic                                  oLast,
`ifdef DRAIN_PARITY_EN
  output logic                                  oParity,
`endif
  output logic                                  oBusy
);

  localparam int EW = elem_w(BITWIDTH);
  localparam int NE = N * N;
  localparam int IW = clog2_min1(N);
  localparam int KW = clog2_min1(NE);
  localparam int CW = clog2_min1(SETTLE_CYCLES + 1);

  state_t           state, state_n;
  logic [NE*EW-1:0] snap, snap_n;
  logic [KW-1:0]    k, k_n;
  logic             valid_n, last_n, tmr_load, tmr_done;
  logic [EW-1:0]    data_n;
  logic [IW-1:0]    row_n, col_n;
  int               next_idx;

  drain_settle_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (CW'(SETTLE_CYCLES)),
    .en       (state == ST_WAIT),
    .done     (tmr_done)
  );

  // Output registers are loaded with the element that will be presented
  // next, so oData/oRow/oCol/oLast never depend combinationally on iReady.
  always_comb begin
    state_n  = state;
    snap_n   = snap;
    k_n      = k;
    tmr_load = 1'b0;
    valid_n  = oValid;
    data_n   = oData;
    row_n    = oRow;
    col_n    = oCol;
    last_n   = oLast;
    next_idx = int'(k) + 1;
    case (state)
      ST_IDLE: if (iStart) begin
        state_n  = ST_WAIT;
        tmr_load = 1'b1;
      end
      ST_WAIT: if (tmr_done) begin
        state_n = ST_STREAM;
        snap_n  = iRes;
        k_n     = '0;
        valid_n = 1'b1;
        data_n  = iRes[EW-1:0];
        row_n   = '0;
        col_n   = '0;
        last_n  = (NE == 1);
      end
      ST_STREAM: if (oValid && iReady) begin
        if (oLast) begin
          state_n = ST_IDLE;
          k_n     = '0;
          valid_n = 1'b0;
          data_n  = '0;
          row_n   = '0;
          col_n   = '0;
          last_n  = 1'b0;
        end else begin
          k_n    = KW'(next_idx);
          data_n = snap[next_idx*EW +: EW];
          row_n  = IW'(next_idx / N);
          col_n  = IW'(next_idx % N);
          last_n = (next_idx == NE - 1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      snap   <= '0;
      k      <= '0;
      oValid <= 1'b0;
      oData  <= '0;
      oRow   <= '0;
      oCol   <= '0;
      oLast  <= 1'b0;
    end else begin
      state  <= state_n;
      snap   <= snap_n;
      k      <= k_n;
      oValid <= valid_n;
      oData  <= data_n;
      oRow   <= row_n;
      oCol   <= col_n;
      oLast  <= last_n;
    end
  end

`ifdef DRAIN_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) oParity <= 1'b0;
    else        oParity <= valid_n & (^data_n);
  end
`endif

  assign oBusy = (state != ST_IDLE);

endmodule

// File: tb/tb_systolic_result_drain.sv
// Randomized directed bench for systolic_result_drain (N=4, BITWIDTH=8, SETTLE_CYCLES=10).
module tb_systolic_result_drain;

  localparam int N      = 4;
  localparam int BW     = 8;
  localparam int SETTLE = 10;
  localparam int NE     = N * N;
  localparam int EW     = 2 * BW;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              iStart = 1'b0;
  logic [NE*EW-1:0]  iRes = '0;
  logic              iReady = 1'b0;
  logic              oValid, oLast, oBusy;
  logic [EW-1:0]     oData;
  logic [1:0]        oRow, oCol;
`ifdef DRAIN_PARITY_EN
  logic              oParity;
`endif

  int vectors = 0;
  int errors  = 0;

  systolic_result_drain #(.N(N), .BITWIDTH(BW), .SETTLE_CYCLES(SETTLE)) dut (
    .clk    (clk),
    .reset  (reset),
    .iStart (iStart),
    .iRes   (iRes),
    .iReady (iReady),
    .oValid (oValid),
    .oData  (oData),
    .oRow   (oRow),
    .oCol   (oCol),
    .oLast  (oLast),
`ifdef DRAIN_PARITY_EN
    .oParity(oParity),
`endif
    .oBusy  (oBusy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, oValid, 0);
    chk({tag, "_data"},  oData, 0);
    chk({tag, "_row"},   oRow, 0);
    chk({tag, "_col"},   oCol, 0);
    chk({tag, "_last"},  oLast, 0);
    chk({tag, "_busy"},  oBusy, 0);
`ifdef DRAIN_PARITY_EN
    chk({tag, "_parity"}, oParity, 0);
`endif
  endtask

  // Caller is positioned just after a falling edge. mode: 0 ready always,
  // 1 ready pattern 1,0,0,1, 2 random ready.
  task automatic run(input logic [NE*EW-1:0] res, input int mode, input bit rewrite, input bit poke);
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] prev_data, e;
    logic [1:0]    prev_row, prev_col;
    logic          prev_last;
    bit            stalled, first, r;
    int            idx, cyc;
    exp_q.delete();
    for (int i = 0; i < NE; i++) exp_q.push_back(res[i*EW +: EW]);
    iRes   = res;
    iStart = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    chk("busy_after_start", oBusy, 1);
    for (int c = 1; c <= SETTLE; c++) begin
      @(negedge clk);
      chk("valid_during_wait", oValid, 0);
      iStart = (poke && c == 3);
      iReady = 1'($urandom_range(0, 1));
    end
    iStart = 1'b0;
    idx = 0; cyc = 0; stalled = 0; first = 1;
    prev_data = '0; prev_row = '0; prev_col = '0; prev_last = 1'b0;
    while (idx < NE && cyc < 200) begin
      @(negedge clk);
      iStart = 1'b0;
      if (first) begin
        chk("first_valid", oValid, 1);
        if (rewrite) iRes = '1;
      end
      if (oValid) begin
        e = exp_q[idx];
        chk("data", oData, e);
        chk("row",  oRow, idx / N);
        chk("col",  oCol, idx % N);
        chk("last", oLast, idx == NE - 1);
`ifdef DRAIN_PARITY_EN
        chk("parity", oParity, ^e);
`endif
        if (stalled) begin
          chk("stall_data", oData, prev_data);
          chk("stall_rowcol", {oRow, oCol, oLast}, {prev_row, prev_col, prev_last});
        end
      end else begin
        chk("valid_in_stream", oValid, 1);
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      iReady    = r;
      stalled   = oValid && !r;
      prev_data = oData; prev_row = oRow; prev_col = oCol; prev_last = oLast;
      if (oValid && r) begin
        if (poke && idx == NE - 1) iStart = 1'b1;
        idx++;
      end
      first = 0;
      cyc++;
    end
    if (idx < NE) chk("stream_timeout", idx, NE);
    if (mode == 0) chk("b2b_cycles", cyc, NE);
    @(negedge clk);
    iStart = 1'b0;
    chk("end_valid", oValid, 0);
    chk("end_busy",  oBusy, 0);
    chk("end_last",  oLast, 0);
  endtask

  task automatic reset_abort(input logic [NE*EW-1:0] res, input int cycles_in, input string tag);
    iRes   = res;
    iStart = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    iReady = 1'b1;
    repeat (cycles_in) @(negedge clk);
    #3 reset = 1'b0;
    #1 chk_idle_outputs(tag);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk({tag, "_post_valid"}, oValid, 0);
      chk({tag, "_post_busy"},  oBusy, 0);
    end
  endtask

  logic [NE*EW-1:0] dir, rnd;

  initial begin
    for (int i = 0; i < NE; i++) dir[i*EW +: EW] = EW'(i + 1);
    repeat (2) @(negedge clk);
    chk_idle_outputs("in_reset");
    reset = 1'b1;
    @(negedge clk);
    chk_idle_outputs("after_reset");

    run(dir, 0, 0, 0);
    run(dir, 1, 0, 0);
    run(dir, 0, 1, 0);
    run(dir, 2, 0, 1);
    run(dir, 0, 0, 1);
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NE; i++) rnd[i*EW +: EW] = EW'($urandom);
      run(rnd, 2, t[0], t[1]);
    end

    reset_abort(dir, 14, "rst_stream");
    reset_abort(dir, 4, "rst_wait");
    run(dir, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Output-side reader for the N x N systolic array; the array consumes flattened operand matrices and produces a flattened result vector.
- On a start pulse, waits a fixed settle time for the array to finish, then snapshots the result vector into a shadow register.
- Streams the N*N result elements out one per handshake, row-major, on a valid/ready interface toward downstream writeback.

Parameters:
- N, 4, array dimension; elements per result = N*N.
- BITWIDTH, 8, operand width; result element width = 2*BITWIDTH.
- SETTLE_CYCLES, 3*N-2, cycles from start acceptance to result snapshot. Must be >= 0.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- iStart  in  1  single-cycle pulse: operands have just been applied to the array.
- iRes  in  N*N*2*BITWIDTH  flattened array result; element k = r*N+c at iRes[k*2*BITWIDTH +: 2*BITWIDTH], element 0 at the LSBs.
- iReady  in  1  downstream can accept oData this cycle.
- oValid  out  1  oData/oRow/oCol/oLast are valid.
- oData  out  2*BITWIDTH  current result element.
- oRow  out  clog2(N) (min 1)  row index of oData.
- oCol  out  clog2(N) (min 1)  column index of oData.
- oLast  out  1  high with the final element (k = N*N-1).
- oBusy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset low, asynchronous): state = IDLE; snapshot and index = 0; oValid, oData, oRow, oCol, oLast, oBusy = 0. Reset asserted mid-WAIT or mid-STREAM aborts immediately and discards the snapshot.
- States: IDLE, WAIT, STREAM.
- IDLE:
  - iStart = 1 at an edge -> WAIT, settle counter = SETTLE_CYCLES.
  - Otherwise stay in IDLE.
- WAIT:
  - Counter != 0 -> decrement.
  - Counter == 0 -> capture iRes into snapshot, index k = 0 -> STREAM.
  - Latency: iStart sampled at edge t; capture at edge t+1+SETTLE_CYCLES; oValid is first high after that edge. SETTLE_CYCLES = 0 captures at edge t+1.
- STREAM:
  - oValid = 1.
  - oData = snapshot element k; oRow = k / N; oCol = k % N; oLast = (k == N*N-1).
  - Transfer occurs on an edge where oValid && iReady.
  - While oValid && !iReady, all outputs hold stable and k is unchanged.
  - Transfer with k < N*N-1 -> k+1.
  - Transfer with oLast -> IDLE, oValid = 0 after that edge.
- iStart while oBusy = 1 is ignored, including the cycle of the final transfer. No queuing.
- iRes changes after capture have no effect on the stream.
- Back-to-back: with iReady held high, the stream takes exactly N*N cycles.
- All outputs are registered. No combinational path from iReady to oValid.

Optional Feature:
- Macro: DRAIN_PARITY_EN.
- Defined: extra output oParity (1 bit), registered alongside oData; equals the XOR reduction of oData (even parity); 0 in reset and whenever oValid = 0.
- Undefined: port absent; no parity logic.

Decomposition:
- Shared package systolic_pkg holds:
  - state encoding constants for IDLE/WAIT/STREAM (2-bit);
  - the element-width constant expression 2*BITWIDTH;
  - a clog2 helper function.
  The array top and this block share it.
- One natural sub-module: drain_settle_timer. It holds the loadable down-counter with a done flag and reset to 0. The rest (FSM, snapshot, index/mux) stays in systolic_result_drain.

Test Plan (N=4, BITWIDTH=8, SETTLE_CYCLES=10, iRes element k = 16'(k+1)):
- Reset low for 2 cycles mid-run -> all outputs 0 and oBusy = 0 immediately (asynchronous), no transfers afterward until a new iStart.
- iStart at edge 0, iReady = 1 -> oValid first high after edge 11. oData sequence 0001..0010 on consecutive cycles; oRow/oCol 0/0, 0/1 ... 3/3; oLast only on 0010; oValid low after edge 27.
- Same stimulus with iReady toggled 1,0,0,1 repeating -> identical 16-element sequence, outputs stable during stalls, no drops or duplicates.
- iRes rewritten to all-FFFF one cycle after capture -> streamed data still 0001..0010.
- iStart pulsed during WAIT and on the final transfer cycle -> ignored. oBusy = 0 after the last transfer; a fresh iStart one cycle later starts a new run.
- DRAIN_PARITY_EN defined, element 0x0007 -> oParity = 1; element 0x0003 -> oParity = 0; oParity = 0 while oValid = 0.
